nic2noc_vc_tracker: RTL and testbench

//  Sits downstream of the NiC slave interface, on the NiC->NoC link. Tracks the

---
 rtl/nic2noc_vc_tracker.sv | 160 ++++++++++++++++
 tb/tb_nic2noc_vc_tracker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nic2noc_vc_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : nic2noc_vc_tracker
//  Description : Per-output-VC busy/idle, ownership and downstream credit
//                tracking on the NiC->NoC link; forwards router credits to
//                the fifo_out_buffer that owns each VC.
//  Revision    : 1.0 - initial release
// ============================================================================
module nic2noc_vc_tracker #(
    parameter int N_TOT_OF_VC            = 6,
    parameter int N_BITS_FIFO_OUT_BUFFER = 3,
    parameter int N_BITS_CREDIT          = 4,
    parameter int N_BUFFER_SLOTS         = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [N_TOT_OF_VC-1:0]                        g_fifo_pointer_i,
    input  logic [N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER-1:0] g_fifo_out_buffer_id_i,
    input  logic [N_TOT_OF_VC-1:0]                        release_pointer_i,
    input  logic                                          is_valid_i,
    input  logic [N_TOT_OF_VC-1:0]                        flit_vc_i,
    input  logic [N_TOT_OF_VC-1:0]                        credit_in_i,
    output logic [N_TOT_OF_VC-1:0]                        credit_signal_o,
    output logic [N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER-1:0] fifo_pointed_o,
    output logic [N_TOT_OF_VC-1:0]                        vc_free_o,
    output logic                                          error_o
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ALLOCATED = 2'd1;
    localparam logic [1:0] c_DRAINING  = 2'd2;

    localparam logic [N_BITS_CREDIT-1:0] c_FULL  = N_BITS_CREDIT'(N_BUFFER_SLOTS);
    localparam logic [N_BITS_CREDIT-1:0] c_EMPTY = '0;

    logic                   w_flit_onehot;
    logic                   w_flit_legal;
    logic                   w_flit_bad;
    logic [N_TOT_OF_VC-1:0] w_err_vc;
    logic                   r_error;

    // A malformed flit_vc_i is dropped entirely rather than charged to any VC.
    assign w_flit_onehot = (flit_vc_i != '0) &&
                           ((flit_vc_i & (flit_vc_i - N_TOT_OF_VC'(1))) == '0);
    assign w_flit_legal  = is_valid_i && w_flit_onehot;
    assign w_flit_bad    = is_valid_i && !w_flit_onehot;

    genvar v;
    generate
        for (v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
            logic [1:0]                        r_state;
            logic [1:0]                        w_state_nxt;
            logic [N_BITS_CREDIT-1:0]          r_credit;
            logic [N_BITS_CREDIT-1:0]          w_credit_nxt;
            logic [N_BITS_FIFO_OUT_BUFFER-1:0] r_owner;
            logic [N_BITS_FIFO_OUT_BUFFER-1:0] w_owner_nxt;
            logic                              r_fwd;
            logic [N_BITS_FIFO_OUT_BUFFER-1:0] r_pointed;
            logic                              w_flit_hit;
            logic                              w_dec;
            logic                              w_inc;
            logic                              w_err;

            assign w_flit_hit = w_flit_legal && flit_vc_i[v];
            assign w_dec      = w_flit_hit && (r_state == c_ALLOCATED);
            assign w_inc      = credit_in_i[v];

            always_comb begin
                w_state_nxt  = r_state;
                w_credit_nxt = r_credit;
                w_owner_nxt  = r_owner;
                w_err        = 1'b0;

                if (w_flit_hit && (r_state != c_ALLOCATED)) begin
                    w_err = 1'b1;
                end

                // Simultaneous flit and credit cancel out, even at the limits.
                if (w_inc && !w_dec) begin
                    if (r_credit == c_FULL) begin
                        w_err = 1'b1;
                    end else begin
                        w_credit_nxt = r_credit + N_BITS_CREDIT'(1);
                    end
                end else if (w_dec && !w_inc) begin
                    if (r_credit == c_EMPTY) begin
                        w_err = 1'b1;
                    end else begin
                        w_credit_nxt = r_credit - N_BITS_CREDIT'(1);
                    end
                end

                case (r_state)
                    c_IDLE: begin
                        if (g_fifo_pointer_i[v]) begin
                            w_state_nxt = c_ALLOCATED;
                            w_owner_nxt = g_fifo_out_buffer_id_i[v*N_BITS_FIFO_OUT_BUFFER +: N_BITS_FIFO_OUT_BUFFER];
                        end
                        if (release_pointer_i[v]) begin
                            w_err = 1'b1;
                        end
                    end
                    c_ALLOCATED: begin
                        if (g_fifo_pointer_i[v]) begin
                            w_err = 1'b1;
                        end
                        if (release_pointer_i[v]) begin
                            w_state_nxt = (w_credit_nxt < c_FULL) ? c_DRAINING : c_IDLE;
                        end
                    end
                    c_DRAINING: begin
                        if (g_fifo_pointer_i[v] || release_pointer_i[v]) begin
                            w_err = 1'b1;
                        end
                        if (w_credit_nxt == c_FULL) begin
                            w_state_nxt = c_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = c_IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state   <= c_IDLE;
                    r_credit  <= c_FULL;
                    r_owner   <= '0;
                    r_fwd     <= 1'b0;
                    r_pointed <= '0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_credit  <= w_credit_nxt;
                    r_owner   <= w_owner_nxt;
                    // Only the current owner may see a credit; a drained VC's old owner may be reused.
                    r_fwd     <= w_inc && (r_state == c_ALLOCATED);
                    r_pointed <= r_owner;
                end
            end

            assign credit_signal_o[v]                                                    = r_fwd;
            assign fifo_pointed_o[v*N_BITS_FIFO_OUT_BUFFER +: N_BITS_FIFO_OUT_BUFFER] = r_pointed;
            assign vc_free_o[v]                                                          = (r_state == c_IDLE);
            assign w_err_vc[v]                                                           = w_err;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if ((|w_err_vc) || w_flit_bad) begin
            r_error <= 1'b1;
        end
    end

    assign error_o = r_error;

endmodule
`default_nettype wire

// File: tb/tb_nic2noc_vc_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nic2noc_vc_tracker
//  Description : Scenario bench for nic2noc_vc_tracker with an expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nic2noc_vc_tracker;

    localparam int c_NVC = 6;
    localparam int c_IDW = 3;

    logic                   clk;
    logic                   rst;
    logic [c_NVC-1:0]       g_fifo_pointer_i;
    logic [c_NVC*c_IDW-1:0] g_fifo_out_buffer_id_i;
    logic [c_NVC-1:0]       release_pointer_i;
    logic                   is_valid_i;
    logic [c_NVC-1:0]       flit_vc_i;
    logic [c_NVC-1:0]       credit_in_i;
    logic [c_NVC-1:0]       credit_signal_o;
    logic [c_NVC*c_IDW-1:0] fifo_pointed_o;
    logic [c_NVC-1:0]       vc_free_o;
    logic                   error_o;

    int checks   = 0;
    int failures = 0;

    nic2noc_vc_tracker #(
        .N_TOT_OF_VC           (6),
        .N_BITS_FIFO_OUT_BUFFER(3),
        .N_BITS_CREDIT         (4),
        .N_BUFFER_SLOTS        (4)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .g_fifo_pointer_i      (g_fifo_pointer_i),
        .g_fifo_out_buffer_id_i(g_fifo_out_buffer_id_i),
        .release_pointer_i     (release_pointer_i),
        .is_valid_i            (is_valid_i),
        .flit_vc_i             (flit_vc_i),
        .credit_in_i           (credit_in_i),
        .credit_signal_o       (credit_signal_o),
        .fifo_pointed_o        (fifo_pointed_o),
        .vc_free_o             (vc_free_o),
        .error_o               (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                   rst;
        logic [c_NVC-1:0]       gnt;
        logic [c_NVC*c_IDW-1:0] gid;
        logic [c_NVC-1:0]       rel;
        logic                   vld;
        logic [c_NVC-1:0]       fvc;
        logic [c_NVC-1:0]       cin;
        logic [c_NVC-1:0]       e_sig;
        logic [c_NVC-1:0]       e_free;
        logic                   e_err;
        int                     pvc;
        logic [c_IDW-1:0]       e_id;
    } stim_t;

    typedef struct {
        logic [c_NVC-1:0] sig;
        logic [c_NVC-1:0] free;
        logic             err;
        int               pvc;
        logic [c_IDW-1:0] id;
    } exp_t;

    exp_t sb[$];

    function automatic logic [c_NVC*c_IDW-1:0] gid(input int vc, input int id);
        logic [c_NVC*c_IDW-1:0] r;
        r = '0;
        r[vc*c_IDW +: c_IDW] = c_IDW'(id);
        return r;
    endfunction

    function automatic stim_t mk(input logic r, input logic [c_NVC-1:0] g, input logic [c_NVC*c_IDW-1:0] gi,
                                 input logic [c_NVC-1:0] rl, input logic vd, input logic [c_NVC-1:0] fv,
                                 input logic [c_NVC-1:0] ci, input logic [c_NVC-1:0] es,
                                 input logic [c_NVC-1:0] ef, input logic ee, input int pv, input int eid);
        stim_t s;
        s.rst = r;   s.gnt = g;    s.gid = gi;  s.rel = rl;  s.vld = vd; s.fvc = fv;
        s.cin = ci;  s.e_sig = es; s.e_free = ef; s.e_err = ee; s.pvc = pv; s.e_id = c_IDW'(eid);
        return s;
    endfunction

    // Drives one cycle of stimulus, queues its expectation, then lands #1 after the edge.
    task automatic apply(input stim_t s);
        exp_t e;
        rst = s.rst; g_fifo_pointer_i = s.gnt; g_fifo_out_buffer_id_i = s.gid;
        release_pointer_i = s.rel; is_valid_i = s.vld; flit_vc_i = s.fvc; credit_in_i = s.cin;
        e.sig = s.e_sig; e.free = s.e_free; e.err = s.e_err; e.pvc = s.pvc; e.id = s.e_id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0; g_fifo_pointer_i = '0; g_fifo_out_buffer_id_i = '0; release_pointer_i = '0;
        is_valid_i = 1'b0; flit_vc_i = '0; credit_in_i = '0;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 6'b111111, 0, -1, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 6'b111111, 0, -1, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            checks++; if (vc_free_o !== e.free) begin failures++; $display("FAIL reset[%0d] vc_free_o got %b want %b", i, vc_free_o, e.free); end
            checks++; if (error_o !== e.err) begin failures++; $display("FAIL reset[%0d] error_o got %b want %b", i, error_o, e.err); end
            checks++; if (credit_signal_o !== e.sig) begin failures++; $display("FAIL reset[%0d] credit_signal_o got %b want %b", i, credit_signal_o, e.sig); end
        end
        checks++; if (fifo_pointed_o !== '0) begin failures++; $display("FAIL reset fifo_pointed_o got %h want 0", fifo_pointed_o); end
    endtask

    task automatic test_alloc_forward_drain();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 6'b000100, gid(2, 5), 0, 0, 0, 0, 6'b000000, 6'b111011, 0, -1, 0));
        for (int k = 0; k < 3; k++)
            st.push_back(mk(0, 0, 0, 0, 1, 6'b000100, 0, 6'b000000, 6'b111011, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000100, 6'b000100, 6'b111011, 0, 2, 5));
        st.push_back(mk(0, 0, 0, 0, 1, 6'b000100, 0, 6'b000000, 6'b111011, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 6'b000100, 0, 0, 0, 6'b000000, 6'b111011, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000100, 6'b000000, 6'b111011, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000100, 6'b000000, 6'b111011, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000100, 6'b000000, 6'b111111, 0, -1, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            checks++; if (vc_free_o !== e.free) begin failures++; $display("FAIL alloc[%0d] vc_free_o got %b want %b", i, vc_free_o, e.free); end
            checks++; if (error_o !== e.err) begin failures++; $display("FAIL alloc[%0d] error_o got %b want %b", i, error_o, e.err); end
            checks++; if (credit_signal_o !== e.sig) begin failures++; $display("FAIL alloc[%0d] credit_signal_o got %b want %b", i, credit_signal_o, e.sig); end
            if (e.pvc >= 0) begin
                checks++; if (fifo_pointed_o[e.pvc*c_IDW +: c_IDW] !== e.id) begin failures++; $display("FAIL alloc[%0d] fifo_pointed_o vc%0d got %0d want %0d", i, e.pvc, fifo_pointed_o[e.pvc*c_IDW +: c_IDW], e.id); end
            end
        end
    endtask

    task automatic test_same_cycle();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 6'b010001, gid(0, 3) | gid(4, 6), 0, 0, 0, 0, 6'b000000, 6'b101110, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 1, 6'b000001, 6'b000001, 6'b000001, 6'b101110, 0, 0, 3));
        st.push_back(mk(0, 6'b100000, gid(5, 1), 6'b000001, 0, 0, 0, 6'b000000, 6'b001111, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 6'b110000, 0, 0, 0, 6'b000000, 6'b111111, 0, -1, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            checks++; if (vc_free_o !== e.free) begin failures++; $display("FAIL same_cycle[%0d] vc_free_o got %b want %b", i, vc_free_o, e.free); end
            checks++; if (error_o !== e.err) begin failures++; $display("FAIL same_cycle[%0d] error_o got %b want %b", i, error_o, e.err); end
            checks++; if (credit_signal_o !== e.sig) begin failures++; $display("FAIL same_cycle[%0d] credit_signal_o got %b want %b", i, credit_signal_o, e.sig); end
            if (e.pvc >= 0) begin
                checks++; if (fifo_pointed_o[e.pvc*c_IDW +: c_IDW] !== e.id) begin failures++; $display("FAIL same_cycle[%0d] fifo_pointed_o vc%0d got %0d want %0d", i, e.pvc, fifo_pointed_o[e.pvc*c_IDW +: c_IDW], e.id); end
            end
        end
    endtask

    task automatic test_errors();
        stim_t st[$];
        exp_t  e;
        // Underflow: 5th flit with zero credit; the counter must hold at 0.
        st.push_back(mk(0, 6'b000010, gid(1, 2), 0, 0, 0, 0, 6'b000000, 6'b111101, 0, -1, 0));
        for (int k = 0; k < 4; k++)
            st.push_back(mk(0, 0, 0, 0, 1, 6'b000010, 0, 6'b000000, 6'b111101, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 1, 6'b000010, 0, 6'b000000, 6'b111101, 1, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000010, 6'b000010, 6'b111101, 1, 1, 2));
        st.push_back(mk(0, 0, 0, 6'b000010, 0, 0, 0, 6'b000000, 6'b111101, 1, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000010, 6'b000000, 6'b111101, 1, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000010, 6'b000000, 6'b111101, 1, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000010, 6'b000000, 6'b111111, 1, -1, 0));
        // Grant on a busy VC must not overwrite the owner.
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 6'b111111, 0, -1, 0));
        st.push_back(mk(0, 6'b000010, gid(1, 2), 0, 0, 0, 0, 6'b000000, 6'b111101, 0, -1, 0));
        st.push_back(mk(0, 6'b000010, gid(1, 7), 0, 0, 0, 0, 6'b000000, 6'b111101, 1, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000010, 6'b000010, 6'b111101, 1, 1, 2));
        st.push_back(mk(0, 0, 0, 6'b000010, 0, 0, 0, 6'b000000, 6'b111111, 1, -1, 0));
        // Non-one-hot flit VC is flagged and leaves the credit untouched.
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 6'b111111, 0, -1, 0));
        st.push_back(mk(0, 6'b001000, gid(3, 4), 0, 0, 0, 0, 6'b000000, 6'b110111, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 1, 6'b001100, 0, 6'b000000, 6'b110111, 1, -1, 0));
        st.push_back(mk(0, 0, 0, 6'b001000, 0, 0, 0, 6'b000000, 6'b111111, 1, -1, 0));
        // Flit on an idle VC.
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 6'b111111, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 1, 6'b000001, 0, 6'b000000, 6'b111111, 1, -1, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            checks++; if (vc_free_o !== e.free) begin failures++; $display("FAIL errors[%0d] vc_free_o got %b want %b", i, vc_free_o, e.free); end
            checks++; if (error_o !== e.err) begin failures++; $display("FAIL errors[%0d] error_o got %b want %b", i, error_o, e.err); end
            checks++; if (credit_signal_o !== e.sig) begin failures++; $display("FAIL errors[%0d] credit_signal_o got %b want %b", i, credit_signal_o, e.sig); end
            if (e.pvc >= 0) begin
                checks++; if (fifo_pointed_o[e.pvc*c_IDW +: c_IDW] !== e.id) begin failures++; $display("FAIL errors[%0d] fifo_pointed_o vc%0d got %0d want %0d", i, e.pvc, fifo_pointed_o[e.pvc*c_IDW +: c_IDW], e.id); end
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 6'b111111, 0, -1, 0));
        st.push_back(mk(0, 6'b001000, gid(3, 4), 0, 0, 0, 0, 6'b000000, 6'b110111, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 1, 6'b001000, 0, 6'b000000, 6'b110111, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 1, 6'b001000, 0, 6'b000000, 6'b110111, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 6'b001000, 0, 0, 0, 6'b000000, 6'b110111, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 0, 1, 6'b001000, 6'b001000, 6'b000000, 6'b110111, 1, -1, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 6'b001000, 6'b000000, 6'b111111, 0, -1, 0));
        st.push_back(mk(0, 6'b001000, gid(3, 4), 0, 0, 0, 0, 6'b000000, 6'b110111, 0, -1, 0));
        st.push_back(mk(0, 0, 0, 6'b001000, 0, 0, 0, 6'b000000, 6'b111111, 0, -1, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            checks++; if (vc_free_o !== e.free) begin failures++; $display("FAIL reset_mid[%0d] vc_free_o got %b want %b", i, vc_free_o, e.free); end
            checks++; if (error_o !== e.err) begin failures++; $display("FAIL reset_mid[%0d] error_o got %b want %b", i, error_o, e.err); end
            checks++; if (credit_signal_o !== e.sig) begin failures++; $display("FAIL reset_mid[%0d] credit_signal_o got %b want %b", i, credit_signal_o, e.sig); end
        end
    endtask

    initial begin
        rst = 1'b1; g_fifo_pointer_i = '0; g_fifo_out_buffer_id_i = '0; release_pointer_i = '0;
        is_valid_i = 1'b0; flit_vc_i = '0; credit_in_i = '0;
        #1;
        test_reset();
        test_alloc_forward_drain();
        test_same_cycle();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
